axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter addr_width, default 32, read address width.
REQ-002 Parameter data_width, default 64, read data width.
REQ-003 Parameter timeout_cyc, default 255 (8-bit), maximum idle cycles allowed between response beats.
REQ-004 AClk  in  1  single clock; all logic on rising edge.
REQ-005 ARst  in  1  reset, asynchronous, active-low.
REQ-006 req  in  4  per-requester read request; bit i belongs to requester i; held high until the grant pulse.
REQ-007 req_addr  in  4*addr_width  per-requester start address; slice i = [i*addr_width +: addr_width].
REQ-008 req_len  in  16  per-requester burst length minus 1, 4 bits each.
REQ-009 req_burst  in  8  per-requester burst type, 2 bits each.
REQ-010 req_size  in  12  per-requester beat size, 3 bits each.
REQ-011 req_tag  in  8  per-requester 2-bit tag, echoed back in the response.
REQ-012 gnt  out  4  one-hot, one-cycle grant pulse.
REQ-013 araddr_d, arburst_d, arlen_d(4), arsize_d  out  -  address and control to the read-channel master.
REQ-014 TXN_ID_R_d  out  4  transaction ID = {granted index[1:0], tag[1:0]}.
REQ-015 rd_trn_en  out  1  one-cycle start pulse to the read-channel master.
REQ-016 rdata_d, rresp_d(2), rid_d(4), rd_rsp_en_d, r_last_d  in  -  response beats from the read-channel master.
REQ-017 rsp_valid  out  4  one-hot per-requester beat strobe.
REQ-018 rsp_data (data_width), rsp_resp (2), rsp_tag (2), rsp_last (1)  out  -  shared response bus, qualified by rsp_valid.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 id_err, timeout_err  out  1 each  one-cycle error pulses.

Function
REQ-021 FSM states: IDLE, GRANT, ISSUE, WAIT; only one transaction outstanding at a time.
REQ-022 IDLE: if req != 0, pick the first set bit searching circularly from rr_ptr; latch index, addr, len, burst, size and tag into holding registers; go to GRANT.
REQ-023 GRANT: gnt[idx]=1 for this cycle only; go to ISSUE.
REQ-024 ISSUE: rd_trn_en=1 for this cycle only; go to WAIT.
REQ-025 araddr_d, arlen_d, arburst_d, arsize_d and TXN_ID_R_d are driven from the holding registers and stay stable from GRANT until the next return to IDLE.
REQ-026 WAIT, beat with rd_rsp_en_d=1 and rid_d[3:2]==idx: in the same cycle, rsp_valid[idx]=1, rsp_data=rdata_d, rsp_resp=rresp_d, rsp_tag=rid_d[1:0], rsp_last=r_last_d.
REQ-027 WAIT, beat with rd_rsp_en_d=1 and rid_d[3:2]!=idx: no rsp_valid for the beat, id_err=1 for one cycle, FSM stays in WAIT.
REQ-028 WAIT: a matching beat with r_last_d=1 completes the transaction: next state IDLE, rr_ptr <= idx+1 mod 4.
REQ-029 r_last_d without rd_rsp_en_d is ignored.
REQ-030 Timeout counter (8-bit): cleared on entry to WAIT and on every rd_rsp_en_d; increments on every other WAIT cycle.
REQ-031 When the timeout counter reaches timeout_cyc: timeout_err=1 for one cycle, next state IDLE, rr_ptr <= idx+1.
REQ-032 A last beat and a timeout in the same cycle: completion wins; no timeout_err.
REQ-033 Requests arriving during GRANT, ISSUE or WAIT are not sampled until the next IDLE cycle.
REQ-034 Dropping req before the grant is legal; it removes the requester from arbitration at the next IDLE evaluation.
REQ-035 Minimum spacing between consecutive grants is 4 cycles (GRANT, ISSUE, at least 1 WAIT, IDLE).

Reset
REQ-036 ARst low asynchronously forces: state IDLE, rr_ptr=0, all holding registers 0, and all outputs 0 (gnt, rd_trn_en, rsp_valid, rsp_*, busy, id_err, timeout_err, araddr_d, TXN_ID_R_d and the other address/control outputs).
REQ-037 Reset during WAIT abandons the transaction: no rsp_valid and no error pulse.
REQ-038 The first IDLE cycle after release may grant.

Verification
REQ-039 Single request: req=4'b0100, len=3, tag=2 -> gnt=4'b0100, then rd_trn_en pulse with TXN_ID_R_d=4'b1010 and arlen_d=3; four beats -> rsp_valid[2] x4, rsp_last on the 4th; busy falls after the 4th beat.
REQ-040 Round-robin: req=4'b1111 held for 4 transactions -> grant order 0,1,2,3, then 0 again.
REQ-041 Wrong ID: beat with rid_d[3:2]=1 while idx=0 -> id_err pulse, rsp_valid=0, FSM stays in WAIT; a subsequent correct last beat completes the transaction.
REQ-042 Timeout: timeout_cyc=8, no beats after ISSUE -> timeout_err on the 8th WAIT cycle, then IDLE, rr_ptr=idx+1.
REQ-043 Reset mid-burst: ARst low after 2 of 4 beats -> all outputs 0 immediately; after release, req=4'b0001 is granted normally.
REQ-044 Last beat and timeout coincident (timeout_cyc=2, last beat arrives on count 2) -> rsp_last delivered, no timeout_err.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter: four read requesters share one read-channel master, one burst outstanding.
// Latency: grant 1 cycle after IDLE sees req, issue pulse next cycle; response beats routed same cycle.
// Backpressure: none on beats; requesters hold req until granted, new requests wait for IDLE.
module axi_read_arbiter #(
    parameter int unsigned addr_width  = 32,
    parameter int unsigned data_width  = 64,
    parameter logic [7:0]  timeout_cyc = 8'd255
) (
    input  logic                    AClk,
    input  logic                    ARst,
    input  logic [3:0]              req,
    input  logic [4*addr_width-1:0] req_addr,
    input  logic [15:0]             req_len,
    input  logic [7:0]              req_burst,
    input  logic [11:0]             req_size,
    input  logic [7:0]              req_tag,
    output logic [3:0]              gnt,
    output logic [addr_width-1:0]   araddr_d,
    output logic [1:0]              arburst_d,
    output logic [3:0]              arlen_d,
    output logic [2:0]              arsize_d,
    output logic [3:0]              TXN_ID_R_d,
    output logic                    rd_trn_en,
    input  logic [data_width-1:0]   rdata_d,
    input  logic [1:0]              rresp_d,
    input  logic [3:0]              rid_d,
    input  logic                    rd_rsp_en_d,
    input  logic                    r_last_d,
    output logic [3:0]              rsp_valid,
    output logic [data_width-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,
    output logic [1:0]              rsp_tag,
    output logic                    rsp_last,
    output logic                    busy,
    output logic                    id_err,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {IDLE, GRANT, ISSUE, WAIT} state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [1:0]              rr_ptr_q;
    logic [1:0]              idx_q;
    logic [addr_width-1:0]   addr_q;
    logic [3:0]              len_q;
    logic [1:0]              burst_q;
    logic [2:0]              size_q;
    logic [1:0]              tag_q;
    logic [7:0]              tmo_cnt_q;

    logic [addr_width-1:0]   addr_arr  [4];
    logic [3:0]              len_arr   [4];
    logic [1:0]              burst_arr [4];
    logic [2:0]              size_arr  [4];
    logic [1:0]              tag_arr   [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*addr_width +: addr_width];
        assign len_arr[i]   = req_len[i*4 +: 4];
        assign burst_arr[i] = req_burst[i*2 +: 2];
        assign size_arr[i]  = req_size[i*3 +: 3];
        assign tag_arr[i]   = req_tag[i*2 +: 2];
    end

    // Circular search for the first requester at or after rr_ptr.
    logic       pick_vld;
    logic [1:0] pick_idx;
    logic [1:0] cand;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = rr_ptr_q;
        cand     = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    logic in_wait;
    logic beat_hit;
    logic beat_miss;
    logic done;
    logic tmo_hit;

    assign in_wait   = (state_q == WAIT);
    assign beat_hit  = in_wait && rd_rsp_en_d && (rid_d[3:2] == idx_q);
    assign beat_miss = in_wait && rd_rsp_en_d && (rid_d[3:2] != idx_q);
    assign done      = beat_hit && r_last_d;
    // Fires on the idle WAIT cycle whose increment would bring the count to the limit;
    // any beat clears the count, so a last beat always beats the timeout.
    assign tmo_hit   = in_wait && !rd_rsp_en_d &&
                       (({1'b0, tmo_cnt_q} + 9'd1) == {1'b0, timeout_cyc});

    always_comb begin
        state_d   = state_q;
        gnt       = 4'b0000;
        rd_trn_en = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (pick_vld) state_d = GRANT;
            end
            GRANT: begin
                gnt     = 4'b0001 << idx_q;
                state_d = ISSUE;
            end
            ISSUE: begin
                rd_trn_en = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (done || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            rr_ptr_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            burst_q  <= '0;
            size_q   <= '0;
            tag_q    <= '0;
        end else begin
            if (state_q == IDLE && pick_vld) begin
                idx_q   <= pick_idx;
                addr_q  <= addr_arr[pick_idx];
                len_q   <= len_arr[pick_idx];
                burst_q <= burst_arr[pick_idx];
                size_q  <= size_arr[pick_idx];
                tag_q   <= tag_arr[pick_idx];
            end
            if (done || tmo_hit) rr_ptr_q <= idx_q + 2'd1;
        end
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst)                             tmo_cnt_q <= '0;
        else if (state_q == ISSUE || rd_rsp_en_d) tmo_cnt_q <= '0;
        else if (in_wait)                      tmo_cnt_q <= tmo_cnt_q + 8'd1;
    end

    assign araddr_d    = addr_q;
    assign arlen_d     = len_q;
    assign arburst_d   = burst_q;
    assign arsize_d    = size_q;
    assign TXN_ID_R_d  = {idx_q, tag_q};

    assign rsp_valid   = beat_hit ? (4'b0001 << idx_q) : 4'b0000;
    assign rsp_data    = beat_hit ? rdata_d    : '0;
    assign rsp_resp    = beat_hit ? rresp_d    : 2'b00;
    assign rsp_tag     = beat_hit ? rid_d[1:0] : 2'b00;
    assign rsp_last    = beat_hit && r_last_d;
    assign id_err      = beat_miss;
    assign timeout_err = tmo_hit;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: the bench plays requesters and read-channel master, checks against a round-robin model.
module tb_axi_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int OW = AW + DW + 30;

    logic            AClk = 1'b0;
    logic            ARst;
    logic [3:0]      req;
    wire  [4*AW-1:0] req_addr;
    wire  [15:0]     req_len;
    wire  [7:0]      req_burst;
    wire  [11:0]     req_size;
    wire  [7:0]      req_tag;
    logic [DW-1:0]   rdata_d;
    logic [1:0]      rresp_d;
    logic [3:0]      rid_d;
    logic            rd_rsp_en_d;
    logic            r_last_d;

    logic [3:0] gnt, TXN_ID_R_d, arlen_d, rsp_valid;
    logic [AW-1:0] araddr_d;
    logic [1:0] arburst_d, rsp_resp, rsp_tag;
    logic [2:0] arsize_d;
    logic [DW-1:0] rsp_data;
    logic rd_trn_en, rsp_last, busy, id_err, timeout_err;

    logic [3:0] t2_gnt, t2_TXN_ID_R_d, t2_arlen_d, t2_rsp_valid;
    logic [AW-1:0] t2_araddr_d;
    logic [1:0] t2_arburst_d, t2_rsp_resp, t2_rsp_tag;
    logic [2:0] t2_arsize_d;
    logic [DW-1:0] t2_rsp_data;
    logic t2_rd_trn_en, t2_rsp_last, t2_busy, t2_id_err, t2_timeout_err;

    always #5 AClk = ~AClk;

    axi_read_arbiter #(.addr_width(AW), .data_width(DW), .timeout_cyc(8'd8)) dut (
        .AClk(AClk), .ARst(ARst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_burst(req_burst), .req_size(req_size), .req_tag(req_tag), .gnt(gnt),
        .araddr_d(araddr_d), .arburst_d(arburst_d), .arlen_d(arlen_d), .arsize_d(arsize_d),
        .TXN_ID_R_d(TXN_ID_R_d), .rd_trn_en(rd_trn_en), .rdata_d(rdata_d), .rresp_d(rresp_d),
        .rid_d(rid_d), .rd_rsp_en_d(rd_rsp_en_d), .r_last_d(r_last_d), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_tag(rsp_tag), .rsp_last(rsp_last),
        .busy(busy), .id_err(id_err), .timeout_err(timeout_err));

    axi_read_arbiter #(.addr_width(AW), .data_width(DW), .timeout_cyc(8'd2)) dut2 (
        .AClk(AClk), .ARst(ARst), .req(req), .req_addr(req_addr), .req_len(req_len),
        .req_burst(req_burst), .req_size(req_size), .req_tag(req_tag), .gnt(t2_gnt),
        .araddr_d(t2_araddr_d), .arburst_d(t2_arburst_d), .arlen_d(t2_arlen_d),
        .arsize_d(t2_arsize_d), .TXN_ID_R_d(t2_TXN_ID_R_d), .rd_trn_en(t2_rd_trn_en),
        .rdata_d(rdata_d), .rresp_d(rresp_d), .rid_d(rid_d), .rd_rsp_en_d(rd_rsp_en_d),
        .r_last_d(r_last_d), .rsp_valid(t2_rsp_valid), .rsp_data(t2_rsp_data),
        .rsp_resp(t2_rsp_resp), .rsp_tag(t2_rsp_tag), .rsp_last(t2_rsp_last), .busy(t2_busy),
        .id_err(t2_id_err), .timeout_err(t2_timeout_err));

    wire [OW-1:0] dut_outs = {gnt, araddr_d, arburst_d, arlen_d, arsize_d, TXN_ID_R_d,
                              rd_trn_en, rsp_valid, rsp_data, rsp_resp, rsp_tag, rsp_last,
                              busy, id_err, timeout_err};
    wire [OW-1:0] dut2_outs = {t2_gnt, t2_araddr_d, t2_arburst_d, t2_arlen_d, t2_arsize_d,
                               t2_TXN_ID_R_d, t2_rd_trn_en, t2_rsp_valid, t2_rsp_data,
                               t2_rsp_resp, t2_rsp_tag, t2_rsp_last, t2_busy, t2_id_err,
                               t2_timeout_err};

    logic [AW-1:0] f_addr  [4];
    logic [3:0]    f_len   [4];
    logic [1:0]    f_burst [4];
    logic [2:0]    f_size  [4];
    logic [1:0]    f_tag   [4];

    for (genvar i = 0; i < 4; i++) begin : g_pack
        assign req_addr[i*AW +: AW] = f_addr[i];
        assign req_len[i*4 +: 4]    = f_len[i];
        assign req_burst[i*2 +: 2]  = f_burst[i];
        assign req_size[i*3 +: 3]   = f_size[i];
        assign req_tag[i*2 +: 2]    = f_tag[i];
    end

    int n_run  = 0;
    int n_fail = 0;
    int rr_m   = 0;

    // Observations captured by the stimulus tasks.
    bit            g_seen;
    int            g_lat;
    logic          g_idle_busy, g_busy, g_rd, i_en;
    logic [3:0]    g_gnt, g_id, g_len, i_gnt, i_id;
    logic [AW-1:0] g_addr, i_addr;
    logic [1:0]    g_burst;
    logic [2:0]    g_size;
    logic [3:0]    o_valid, o2_valid;
    logic [DW-1:0] o_data;
    logic [1:0]    o_resp, o_tag;
    logic          o_last, o_id_err, o_tmo, o_busy, o2_last, o2_tmo, o2_busy;

    function automatic int pick(input logic [3:0] m, input int rr);
        for (int k = 0; k < 4; k++)
            if (m[(rr + k) % 4]) return (rr + k) % 4;
        return 0;
    endfunction

    task automatic rand_fields();
        for (int i = 0; i < 4; i++) begin
            f_addr[i]  = $urandom;
            f_len[i]   = 4'($urandom_range(0, 15));
            f_burst[i] = 2'($urandom_range(0, 3));
            f_size[i]  = 3'($urandom_range(0, 7));
            f_tag[i]   = 2'($urandom_range(0, 3));
        end
    endtask

    // Runs IDLE -> GRANT -> ISSUE; returns at the start of the first WAIT cycle.
    task automatic grant_phase(input bit drop);
        g_seen = 1'b0;
        g_lat  = 0;
        for (int c = 0; c < 8 && !g_seen; c++) begin
            @(negedge AClk);
            if (c == 0) g_idle_busy = busy;
            if (gnt != 4'b0000) begin
                g_seen = 1'b1; g_gnt = gnt; g_busy = busy; g_rd = rd_trn_en; g_id = TXN_ID_R_d;
                g_addr = araddr_d; g_len = arlen_d; g_burst = arburst_d; g_size = arsize_d;
            end else begin
                g_lat++;
            end
            @(posedge AClk); #1;
        end
        if (g_seen) begin
            if (drop) req = req & ~g_gnt;
            @(negedge AClk);
            i_en = rd_trn_en; i_gnt = gnt; i_id = TXN_ID_R_d; i_addr = araddr_d;
            @(posedge AClk); #1;
        end
    endtask

    task automatic beat(input bit en, input logic [3:0] rid, input bit last,
                        input logic [DW-1:0] d, input logic [1:0] resp);
        rd_rsp_en_d = en; rid_d = rid; r_last_d = last; rdata_d = d; rresp_d = resp;
        @(negedge AClk);
        o_valid = rsp_valid; o_data = rsp_data; o_resp = rsp_resp; o_tag = rsp_tag;
        o_last = rsp_last; o_id_err = id_err; o_tmo = timeout_err; o_busy = busy;
        o2_valid = t2_rsp_valid; o2_last = t2_rsp_last; o2_tmo = t2_timeout_err; o2_busy = t2_busy;
        @(posedge AClk); #1;
        rd_rsp_en_d = 1'b0; r_last_d = 1'b0;
    endtask

    task automatic test_reset();
        ARst = 1'b0; req = 4'b1111; rd_rsp_en_d = 1'b1; r_last_d = 1'b1; rid_d = 4'b0000;
        rdata_d = '1; rresp_d = 2'b11;
        rand_fields();
        repeat (2) @(posedge AClk);
        @(negedge AClk);
        n_run++;
        if (dut_outs !== '0) begin
            n_fail++; $display("FAIL reset_outs: got %h expected 0", dut_outs);
        end
        n_run++;
        if (dut2_outs !== '0) begin
            n_fail++; $display("FAIL reset_outs2: got %h expected 0", dut2_outs);
        end
        @(posedge AClk); #1;
        req = 4'b0000; rd_rsp_en_d = 1'b0; r_last_d = 1'b0; ARst = 1'b1; rr_m = 0;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] eid;
        rand_fields();
        for (int i = 0; i < 4; i++) f_len[i] = 4'd0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            grant_phase(1'b0);
            n_run++;
            if (!g_seen || g_lat != 1) begin
                n_fail++; $display("FAIL rr_latency: seen %0d lat %0d expected 1", g_seen, g_lat);
                return;
            end
            eid = {2'(order[k]), f_tag[order[k]]};
            n_run++;
            if ({g_gnt, g_id} !== {4'b0001 << order[k], eid}) begin
                n_fail++; $display("FAIL rr_order[%0d]: got %b/%b expected %b/%b", k, g_gnt, g_id,
                                   4'b0001 << order[k], eid);
            end
            beat(1'b1, eid, 1'b1, '0, 2'b00);
            rr_m = (order[k] + 1) % 4;
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        rand_fields();
        f_len[2] = 4'd3; f_tag[2] = 2'd2;
        req = 4'b0100;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_lat != 1 || g_gnt !== 4'b0100 || g_rd !== 1'b0) begin
            n_fail++; $display("FAIL single_gnt: got %b lat %0d expected 0100 lat 1", g_gnt, g_lat);
            return;
        end
        n_run++;
        if ({i_en, i_gnt, i_id, g_len, g_addr} !== {1'b1, 4'b0000, 4'b1010, 4'd3, f_addr[2]}) begin
            n_fail++; $display("FAIL single_issue: en %b id %b len %0d expected 1 1010 3", i_en, i_id, g_len);
        end
        for (int b = 0; b < 4; b++) begin
            d = {$urandom, $urandom};
            beat(1'b1, 4'b1010, b == 3, d, 2'(b));
            n_run++;
            if ({o_valid, o_data, o_resp, o_tag, o_last} !== {4'b0100, d, 2'(b), 2'd2, b == 3}) begin
                n_fail++; $display("FAIL single_beat[%0d]: valid %b last %b data %h expected 0100 %0d %h",
                                   b, o_valid, o_last, o_data, b == 3, d);
            end
        end
        beat(1'b0, 4'b0000, 1'b0, '0, 2'b00);
        n_run++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL single_busy_fall: got %b expected 0", o_busy);
        end
        rr_m = 3;
    endtask

    task automatic test_wrong_id();
        logic [3:0] eid;
        rand_fields();
        req = 4'b0001;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_gnt !== 4'b0001) begin
            n_fail++; $display("FAIL wid_gnt: got %b expected 0001", g_gnt);
            return;
        end
        eid = {2'd0, f_tag[0]};
        for (int k = 0; k < 2; k++) begin
            beat(1'b1, {2'd1, f_tag[0]}, k == 1, '1, 2'b01);
            n_run++;
            if ({o_valid, o_id_err, o_busy} !== {4'b0000, 1'b1, 1'b1}) begin
                n_fail++; $display("FAIL wid_bad[%0d]: valid %b id_err %b busy %b expected 0000 1 1",
                                   k, o_valid, o_id_err, o_busy);
            end
        end
        beat(1'b0, eid, 1'b1, '0, 2'b00);
        n_run++;
        if ({o_valid, o_id_err, o_busy} !== {4'b0000, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL wid_stray_last: valid %b id_err %b busy %b expected 0000 0 1",
                               o_valid, o_id_err, o_busy);
        end
        beat(1'b1, eid, 1'b1, 64'h1234, 2'b10);
        n_run++;
        if ({o_valid, o_last, o_id_err, o_data} !== {4'b0001, 1'b1, 1'b0, 64'h1234}) begin
            n_fail++; $display("FAIL wid_good_last: valid %b last %b id_err %b expected 0001 1 0",
                               o_valid, o_last, o_id_err);
        end
        beat(1'b0, 4'b0000, 1'b0, '0, 2'b00);
        n_run++;
        if (o_busy !== 1'b0) begin
            n_fail++; $display("FAIL wid_done: busy %b expected 0", o_busy);
        end
        rr_m = 1;
    endtask

    task automatic test_timeout();
        int exp;
        rand_fields();
        req = 4'b0010;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_gnt !== 4'b0010) begin
            n_fail++; $display("FAIL tmo_gnt: got %b expected 0010", g_gnt);
            return;
        end
        for (int w = 1; w <= 8; w++) begin
            beat(1'b0, 4'b0000, 1'b0, '0, 2'b00);
            n_run++;
            if ({o_tmo, o_busy} !== {w == 8, 1'b1}) begin
                n_fail++; $display("FAIL tmo_cycle[%0d]: tmo %b busy %b expected %0d 1", w, o_tmo, o_busy, w == 8);
            end
        end
        rr_m = 2;
        req = 4'b1111;
        exp = pick(req, rr_m);
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_lat != 1 || g_idle_busy !== 1'b0 || g_gnt !== 4'b0001 << exp) begin
            n_fail++; $display("FAIL tmo_rr_next: got %b lat %0d idle_busy %b expected %b lat 1 busy 0",
                               g_gnt, g_lat, g_idle_busy, 4'b0001 << exp);
            return;
        end
        beat(1'b1, {2'(exp), f_tag[exp]}, 1'b1, '0, 2'b00);
        rr_m = (exp + 1) % 4;
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_burst();
        rand_fields();
        f_len[3] = 4'd3;
        req = 4'b1000;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_gnt !== 4'b1000) begin
            n_fail++; $display("FAIL rmid_gnt: got %b expected 1000", g_gnt);
            return;
        end
        for (int b = 0; b < 2; b++) beat(1'b1, {2'd3, f_tag[3]}, 1'b0, '1, 2'b00);
        n_run++;
        if (o_valid !== 4'b1000) begin
            n_fail++; $display("FAIL rmid_beat: valid %b expected 1000", o_valid);
        end
        rd_rsp_en_d = 1'b1; rid_d = {2'd3, f_tag[3]}; r_last_d = 1'b1; rdata_d = '1;
        ARst = 1'b0;
        #1;
        n_run++;
        if (dut_outs !== '0) begin
            n_fail++; $display("FAIL rmid_outs: got %h expected 0", dut_outs);
        end
        @(posedge AClk); #1;
        rd_rsp_en_d = 1'b0; r_last_d = 1'b0; ARst = 1'b1; rr_m = 0;
        rand_fields();
        f_len[0] = 4'd0;
        req = 4'b0001;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_lat != 1 || {g_gnt, g_id} !== {4'b0001, 2'd0, f_tag[0]}) begin
            n_fail++; $display("FAIL rmid_regrant: got %b id %b lat %0d expected 0001 id %b lat 1",
                               g_gnt, g_id, g_lat, {2'd0, f_tag[0]});
            return;
        end
        beat(1'b1, {2'd0, f_tag[0]}, 1'b1, '0, 2'b00);
        rr_m = 1;
    endtask

    task automatic test_coincident();
        ARst = 1'b0;
        @(posedge AClk); #1;
        ARst = 1'b1; rr_m = 0;
        rand_fields();
        req = 4'b0001;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_gnt !== 4'b0001) begin
            n_fail++; $display("FAIL coin_gnt: got %b expected 0001", g_gnt);
            return;
        end
        beat(1'b0, 4'b0000, 1'b0, '0, 2'b00);
        n_run++;
        if ({o2_tmo, o2_busy} !== 2'b01) begin
            n_fail++; $display("FAIL coin_wait1: tmo %b busy %b expected 0 1", o2_tmo, o2_busy);
        end
        beat(1'b1, {2'd0, f_tag[0]}, 1'b1, '0, 2'b00);
        n_run++;
        if ({o2_valid, o2_last, o2_tmo} !== {4'b0001, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL coin_last_wins: valid %b last %b tmo %b expected 0001 1 0",
                               o2_valid, o2_last, o2_tmo);
        end
        req = 4'b0010;
        grant_phase(1'b1);
        n_run++;
        if (!g_seen || g_gnt !== 4'b0010) begin
            n_fail++; $display("FAIL coin_gnt2: got %b expected 0010", g_gnt);
            return;
        end
        for (int w = 1; w <= 3; w++) begin
            beat(1'b0, 4'b0000, 1'b0, '0, 2'b00);
            n_run++;
            if ({o2_tmo, o2_busy} !== {w == 2, w != 3}) begin
                n_fail++; $display("FAIL coin_tmo2[%0d]: tmo %b busy %b expected %0d %0d",
                                   w, o2_tmo, o2_busy, w == 2, w != 3);
            end
        end
        beat(1'b1, {2'd1, f_tag[1]}, 1'b1, '0, 2'b00);
        n_run++;
        if ({o_valid, o_last} !== {4'b0010, 1'b1}) begin
            n_fail++; $display("FAIL coin_main_done: valid %b last %b expected 0010 1", o_valid, o_last);
        end
        rr_m = 2;
    endtask

    task automatic test_random();
        int exp, nb, gap, kind;
        logic [3:0] mask, eid;
        logic [DW-1:0] d;
        logic [1:0] rs;
        bit lst;
        for (int t = 0; t < 40; t++) begin
            rand_fields();
            mask = 4'($urandom_range(1, 15));
            req = mask;
            exp = pick(mask, rr_m);
            eid = {2'(exp), f_tag[exp]};
            grant_phase(1'b1);
            n_run++;
            if (!g_seen || g_lat != 1 || g_idle_busy !== 1'b0) begin
                n_fail++; $display("FAIL rand_lat[%0d]: seen %0d lat %0d idle_busy %b expected 1 1 0",
                                   t, g_seen, g_lat, g_idle_busy);
                return;
            end
            n_run++;
            if ({g_gnt, g_busy, g_rd, g_id} !== {4'b0001 << exp, 1'b1, 1'b0, eid}) begin
                n_fail++; $display("FAIL rand_gnt[%0d]: got %b id %b expected %b id %b",
                                   t, g_gnt, g_id, 4'b0001 << exp, eid);
            end
            n_run++;
            if ({g_addr, g_len, g_burst, g_size} !== {f_addr[exp], f_len[exp], f_burst[exp], f_size[exp]}) begin
                n_fail++; $display("FAIL rand_fields[%0d]: got %h %h %h %h expected %h %h %h %h", t,
                                   g_addr, g_len, g_burst, g_size, f_addr[exp], f_len[exp], f_burst[exp], f_size[exp]);
            end
            n_run++;
            if ({i_en, i_gnt, i_id, i_addr} !== {1'b1, 4'b0000, eid, f_addr[exp]}) begin
                n_fail++; $display("FAIL rand_issue[%0d]: en %b gnt %b id %b expected 1 0000 %b",
                                   t, i_en, i_gnt, i_id, eid);
            end
            nb = int'(f_len[exp]) + 1;
            for (int b = 0; b < nb; b++) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    kind = $urandom_range(0, 2);
                    if (kind == 2)
                        beat(1'b1, {2'((exp + 1 + $urandom_range(0, 2)) % 4), 2'($urandom)},
                             1'($urandom), {$urandom, $urandom}, 2'($urandom));
                    else
                        beat(1'b0, 4'($urandom), kind == 1, {$urandom, $urandom}, 2'($urandom));
                    n_run++;
                    if ({o_valid, o_id_err, o_tmo, o_busy} !== {4'b0000, kind == 2, 1'b0, 1'b1}) begin
                        n_fail++; $display("FAIL rand_gap[%0d.%0d]: valid %b id_err %b tmo %b busy %b kind %0d",
                                           t, b, o_valid, o_id_err, o_tmo, o_busy, kind);
                    end
                end
                d = {$urandom, $urandom};
                rs = 2'($urandom);
                lst = (b == nb - 1);
                beat(1'b1, eid, lst, d, rs);
                n_run++;
                if ({o_valid, o_data, o_resp, o_tag, o_last, o_id_err, o_tmo} !==
                    {4'b0001 << exp, d, rs, f_tag[exp], lst, 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL rand_beat[%0d.%0d]: valid %b data %h last %b expected %b %h %0d",
                                       t, b, o_valid, o_data, o_last, 4'b0001 << exp, d, lst);
                end
            end
            rr_m = (exp + 1) % 4;
        end
        req = 4'b0000;
    endtask

    initial begin
        req = 4'b0000; rd_rsp_en_d = 1'b0; r_last_d = 1'b0; rid_d = 4'b0000;
        rdata_d = '0; rresp_d = 2'b00;
        test_reset();
        test_round_robin();
        test_single();
        test_wrong_id();
        test_timeout();
        test_reset_mid_burst();
        test_coincident();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
